// File: rtl/fifo_word_packer.sv
// Drains an 8-bit byte FIFO and packs BYTES_PER_WORD bytes little-endian into a valid/ready word.
// Optional partial-word flush after FLUSH_CYCLES idle cycles is enabled by defining PACKER_FLUSH_EN.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_CYCLES   = 16,
  localparam int CW = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fifo_empty,
  input  logic [7:0]                  fifo_data,
  output logic                        fifo_rd_en,
  output logic [8*BYTES_PER_WORD-1:0] word_data,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [CW-1:0]               word_bytes,
  output logic [15:0]                 words_sent
);

  localparam logic [CW-1:0] BPW = CW'(BYTES_PER_WORD);

  typedef enum logic {FILL = 1'b0, OUT = 1'b1} state_t;

  state_t                                state, state_nxt;
  logic                                  rd_q;
  logic [CW-1:0]                         req_cnt, byte_cnt;
  logic [BYTES_PER_WORD-1:0][7:0]        word_q;
  logic                                  last_byte, flush;

  assign last_byte  = rd_q && (byte_cnt == BPW - CW'(1));
  assign word_data  = word_q;
  assign word_valid = (state == OUT);

`ifdef PACKER_FLUSH_EN
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
  logic          idle_cyc;

  // Only a started, incomplete word with nothing in flight counts as idle.
  assign idle_cyc = (state == FILL) && (byte_cnt != '0) && (byte_cnt < BPW) && !rd_q && fifo_empty;
  assign flush    = idle_cyc && (idle_cnt == IW'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                idle_cnt <= '0;
    else if (!idle_cyc || flush) idle_cnt <= '0;
    else                       idle_cnt <= idle_cnt + IW'(1);
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      FILL: begin
        fifo_rd_en = rst_n && !fifo_empty && (req_cnt < BPW);
        if (last_byte || flush) state_nxt = OUT;
      end
      OUT: if (word_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= 1'b0;
      req_cnt    <= '0;
      byte_cnt   <= '0;
      word_q     <= '0;
      word_bytes <= '0;
      words_sent <= '0;
    end else begin
      rd_q <= fifo_rd_en;
      if (state == OUT) begin
        if (word_ready) begin
          words_sent <= words_sent + 16'd1;
          req_cnt    <= '0;
          byte_cnt   <= '0;
          word_q     <= '0;
          word_bytes <= '0;
        end
      end else begin
        if (fifo_rd_en) req_cnt <= req_cnt + CW'(1);
        if (rd_q) begin
          for (int k = 0; k < BYTES_PER_WORD; k++)
            if (byte_cnt == CW'(k)) word_q[k] <= fifo_data;
          byte_cnt <= byte_cnt + CW'(1);
        end
        if (last_byte)  word_bytes <= BPW;
        else if (flush) word_bytes <= byte_cnt;
      end
    end
  end

endmodule
